// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM states, load/mask codes,
// bus response codes and small request-decoding helpers.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } lsu_state_e;

    localparam logic [2:0] LC_LB  = 3'b000;
    localparam logic [2:0] LC_LH  = 3'b001;
    localparam logic [2:0] LC_LW  = 3'b010;
    localparam logic [2:0] LC_LBU = 3'b100;
    localparam logic [2:0] LC_LHU = 3'b101;

    localparam logic [3:0] WMASK_BYTE = 4'b0001;
    localparam logic [3:0] WMASK_HALF = 4'b0011;
    localparam logic [3:0] WMASK_WORD = 4'b1111;

    localparam logic [1:0] BUS_RESP_OK     = 2'b00;
    localparam logic [1:0] BUS_RESP_SLVERR = 2'b10;

    // Loads take their size from load_ctl, stores from wmask; unknown sizes never trap.
    function automatic logic isMisaligned(input logic       isLoad,
                                          input logic [2:0] loadCtl,
                                          input logic [3:0] wmask,
                                          input logic [1:0] offset);
        logic isHalf;
        logic isWord;
        if (isLoad) begin
            isHalf = (loadCtl[1:0] == 2'b01);
            isWord = (loadCtl[1:0] == 2'b10);
        end else begin
            isHalf = (wmask == WMASK_HALF);
            isWord = (wmask == WMASK_WORD);
        end
        return (isHalf && offset[0]) || (isWord && (offset != 2'b00));
    endfunction

    function automatic logic [31:0] replicateLane(input logic [31:0] wdata,
                                                  input logic [3:0]  wmask);
        if (wmask == WMASK_BYTE) begin
            return {4{wdata[7:0]}};
        end else if (wmask == WMASK_HALF) begin
            return {2{wdata[15:0]}};
        end
        return wdata;
    endfunction

endpackage

// File: rtl/load_store_unit_load_data_align.sv
// Moves the addressed byte/half of a bus word down to bit 0 and sign- or
// zero-extends it according to the load type.
module load_data_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  load_ctl,
    output logic [31:0] resp_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (load_ctl)
            LC_LB:   resp_data = {{24{shifted[7]}}, shifted[7:0]};
            LC_LH:   resp_data = {{16{shifted[15]}}, shifted[15:0]};
            LC_LW:   resp_data = shifted;
            LC_LBU:  resp_data = {24'h0, shifted[7:0]};
            LC_LHU:  resp_data = {16'h0, shifted[15:0]};
            default: resp_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core memory request into an AXI-lite style read or
// write transaction and returns a single-cycle response pulse to the core.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter logic [1:0] RESP_OK    = BUS_RESP_OK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [3:0]            wmask,
    input  logic [2:0]            load_ctl,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    lsu_state_e            state_q;
    logic [DATA_WIDTH-1:0] addrWord_q;
    logic [1:0]            offset_q;
    logic [2:0]            loadCtl_q;
    logic [DATA_WIDTH-1:0] wdataLane_q;
    logic [3:0]            wstrb_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  respValid_q;
    logic                  respErr_q;
    logic [DATA_WIDTH-1:0] respData_q;

    logic [DATA_WIDTH-1:0] wdataLane_d;
    logic [3:0]            wstrb_d;
    logic                  misaligned_d;
    logic [DATA_WIDTH-1:0] loadData_d;
    logic                  awSent_d;
    logic                  wSent_d;

    // A channel counts as sent once its valid has dropped or its handshake happens now.
    always_comb begin
        wdataLane_d  = replicateLane(wdata, wmask);
        wstrb_d      = wmask << addr[1:0];
        misaligned_d = isMisaligned(mem_ren, load_ctl, wmask, addr[1:0]);
        awSent_d     = !awvalid_q || awready;
        wSent_d      = !wvalid_q || wready;
    end

    load_data_align u_align (
        .rdata     (rdata),
        .offset    (offset_q),
        .load_ctl  (loadCtl_q),
        .resp_data (loadData_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addrWord_q  <= '0;
            offset_q    <= '0;
            loadCtl_q   <= '0;
            wdataLane_q <= '0;
            wstrb_q     <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            respValid_q <= 1'b0;
            respErr_q   <= 1'b0;
            respData_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addrWord_q  <= {addr[DATA_WIDTH-1:2], 2'b00};
                        offset_q    <= addr[1:0];
                        loadCtl_q   <= load_ctl;
                        wdataLane_q <= wdataLane_d;
                        wstrb_q     <= wstrb_d;
                        respData_q  <= '0;
                        // Illegal, empty and misaligned requests answer without touching the bus.
                        if ((mem_ren && mem_wen) || ((mem_ren || mem_wen) && misaligned_d)) begin
                            state_q     <= DONE;
                            respValid_q <= 1'b1;
                            respErr_q   <= 1'b1;
                        end else if (!mem_ren && !mem_wen) begin
                            state_q     <= DONE;
                            respValid_q <= 1'b1;
                            respErr_q   <= 1'b0;
                        end else if (mem_ren) begin
                            state_q   <= RD_ADDR;
                            arvalid_q <= 1'b1;
                        end else begin
                            state_q   <= WR_REQ;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready_q    <= 1'b0;
                        respValid_q <= 1'b1;
                        respErr_q   <= (rresp != RESP_OK);
                        respData_q  <= (rresp == RESP_OK) ? loadData_d : '0;
                        state_q     <= DONE;
                    end
                end
                WR_REQ: begin
                    if (awvalid_q && awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (awSent_d && wSent_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready_q    <= 1'b0;
                        respValid_q <= 1'b1;
                        respErr_q   <= (bresp != RESP_OK);
                        respData_q  <= '0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    respValid_q <= 1'b0;
                    respErr_q   <= 1'b0;
                    respData_q  <= '0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = respValid_q;
    assign resp_err   = respErr_q;
    assign resp_data  = respData_q;
    assign araddr     = addrWord_q;
    assign awaddr     = addrWord_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign awvalid    = awvalid_q;
    assign wvalid     = wvalid_q;
    assign bready     = bready_q;
    assign wdata_o    = wdataLane_q;
    assign wstrb      = wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: a scoreboard queue holds the expected
// response of each request and a negedge monitor compares every response pulse.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, mem_ren, mem_wen;
    logic [31:0] addr, wdata;
    logic [3:0]  wmask;
    logic [2:0]  load_ctl;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;
    logic [31:0] araddr, rdata, awaddr, wdata_o;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    typedef struct {
        string       name;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  mask;
        logic [2:0]  ctl;
        logic [31:0] rd;
        logic [1:0]  rresp;
        logic [1:0]  bresp;
        int          awReadyAt;
        logic        expErr;
        logic [31:0] expData;
        int          expLat;
        int          expBus;
        logic [31:0] expAddr;
        logic [3:0]  expStrb;
        logic [31:0] expWdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t       expQ[$];
    resp_t       monExp;
    vec_t        vecs[12];
    int          testsRun = 0;
    int          testsFailed = 0;
    logic        sawAr, sawAw, wDropFirst;
    logic [31:0] seenAraddr, seenAwaddr, seenWdata;
    logic [3:0]  seenWstrb;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .addr       (addr),
        .wdata      (wdata),
        .wmask      (wmask),
        .load_ctl   (load_ctl),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata_o    (wdata_o),
        .wstrb      (wstrb),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every response pulse consumes one expected entry.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected response: got err=%0b data=%h, required none", resp_err, resp_data);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("resp_err", {31'b0, resp_err}, {31'b0, monExp.err});
                checkOutput("resp_data", resp_data, monExp.data);
            end
        end
    end

    task automatic clearBus();
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    endtask

    task automatic applyStimulus(input vec_t v, input bit pushExp);
        int w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        checkOutput({v.name, " req_ready"}, {31'b0, req_ready}, 32'd1);
        mem_ren = v.ren; mem_wen = v.wen; addr = v.addr; wdata = v.wd;
        wmask = v.mask; load_ctl = v.ctl; req_valid = 1'b1;
        if (pushExp) expQ.push_back('{v.expErr, v.expData});
        @(posedge clk); #1;
        req_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
    endtask

    task automatic runVector(input vec_t v);
        int lat = 0;
        rdata = v.rd; rresp = v.rresp; bresp = v.bresp;
        arready = 1'b1; rvalid = 1'b1; wready = 1'b1; bvalid = 1'b1;
        awready = (v.awReadyAt == 0);
        sawAr = 1'b0; sawAw = 1'b0; wDropFirst = 1'b0;
        seenAraddr = '0; seenAwaddr = '0; seenWdata = '0; seenWstrb = '0;
        applyStimulus(v, 1'b1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (arvalid) begin sawAr = 1'b1; seenAraddr = araddr; end
            if (awvalid) begin sawAw = 1'b1; seenAwaddr = awaddr; end
            if (wvalid) begin seenWdata = wdata_o; seenWstrb = wstrb; end
            if (!wvalid && awvalid) wDropFirst = 1'b1;
            if (c == v.awReadyAt) awready = 1'b1;
            if (resp_valid) begin lat = c; break; end
        end
        checkOutput({v.name, " latency"}, lat, v.expLat);
        case (v.expBus)
            1: begin
                checkOutput({v.name, " channels used"}, {30'b0, sawAr, sawAw}, 32'd2);
                checkOutput({v.name, " araddr"}, seenAraddr, v.expAddr);
            end
            2: begin
                checkOutput({v.name, " channels used"}, {30'b0, sawAr, sawAw}, 32'd1);
                checkOutput({v.name, " awaddr"}, seenAwaddr, v.expAddr);
                checkOutput({v.name, " wstrb"}, {28'b0, seenWstrb}, {28'b0, v.expStrb});
                checkOutput({v.name, " wdata_o"}, seenWdata, v.expWdata);
            end
            default: checkOutput({v.name, " no bus access"}, {30'b0, sawAr, sawAw}, 32'd0);
        endcase
        if (v.awReadyAt > 0) checkOutput({v.name, " wvalid drops first"}, {31'b0, wDropFirst}, 32'd1);
        clearBus();
        @(negedge clk);
        checkOutput({v.name, " single pulse"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        //                name    ren   wen   addr          wdata         mask     ctl     rdata         rresp            bresp            awAt err   expData       lat bus expAddr       strb     expWdata
        vecs[0]  = '{"lb",  1'b1, 1'b0, 32'h80000003, 32'h0,        4'b0001, LC_LB,  32'h80FF1234, BUS_RESP_OK,     BUS_RESP_OK,     0, 1'b0, 32'hFFFFFF80, 3, 1, 32'h80000000, 4'b0000, 32'h0};
        vecs[1]  = '{"sh",  1'b0, 1'b1, 32'h80000002, 32'h0000BEEF, 4'b0011, LC_LB,  32'h0,        BUS_RESP_OK,     BUS_RESP_OK,     3, 1'b0, 32'h0,        5, 2, 32'h80000000, 4'b1100, 32'hBEEFBEEF};
        vecs[2]  = '{"lw misaligned", 1'b1, 1'b0, 32'h80000001, 32'h0, 4'b1111, LC_LW, 32'h11111111, BUS_RESP_OK, BUS_RESP_OK, 0, 1'b1, 32'h0,        1, 0, 32'h0,        4'b0000, 32'h0};
        vecs[3]  = '{"lhu slverr", 1'b1, 1'b0, 32'h80000002, 32'h0, 4'b0011, LC_LHU, 32'hCAFE0000, BUS_RESP_SLVERR, BUS_RESP_OK, 0, 1'b1, 32'h0,        3, 1, 32'h80000000, 4'b0000, 32'h0};
        vecs[4]  = '{"ren and wen", 1'b1, 1'b1, 32'h80000000, 32'h0, 4'b1111, LC_LW, 32'h0,       BUS_RESP_OK,     BUS_RESP_OK,     0, 1'b1, 32'h0,        1, 0, 32'h0,        4'b0000, 32'h0};
        vecs[5]  = '{"no-op", 1'b0, 1'b0, 32'h80000000, 32'h0,       4'b1111, LC_LW,  32'h0,        BUS_RESP_OK,     BUS_RESP_OK,     0, 1'b0, 32'h0,        1, 0, 32'h0,        4'b0000, 32'h0};
        vecs[6]  = '{"lh",  1'b1, 1'b0, 32'h80000000, 32'h0,        4'b0011, LC_LH,  32'h12348001, BUS_RESP_OK,     BUS_RESP_OK,     0, 1'b0, 32'hFFFF8001, 3, 1, 32'h80000000, 4'b0000, 32'h0};
        vecs[7]  = '{"lbu", 1'b1, 1'b0, 32'h80000001, 32'h0,        4'b0001, LC_LBU, 32'h80FF1234, BUS_RESP_OK,     BUS_RESP_OK,     0, 1'b0, 32'h00000012, 3, 1, 32'h80000000, 4'b0000, 32'h0};
        vecs[8]  = '{"sb",  1'b0, 1'b1, 32'h80000005, 32'h000000A5, 4'b0001, LC_LB,  32'h0,        BUS_RESP_OK,     BUS_RESP_OK,     0, 1'b0, 32'h0,        3, 2, 32'h80000004, 4'b0010, 32'hA5A5A5A5};
        vecs[9]  = '{"sw slverr", 1'b0, 1'b1, 32'h80000008, 32'hDEADBEEF, 4'b1111, LC_LB, 32'h0,    BUS_RESP_OK,     BUS_RESP_SLVERR, 0, 1'b1, 32'h0,        3, 2, 32'h80000008, 4'b1111, 32'hDEADBEEF};
        vecs[10] = '{"sh misaligned", 1'b0, 1'b1, 32'h80000003, 32'h1234, 4'b0011, LC_LB, 32'h0,   BUS_RESP_OK,     BUS_RESP_OK,     0, 1'b1, 32'h0,        1, 0, 32'h0,        4'b0000, 32'h0};
        vecs[11] = '{"lw",  1'b1, 1'b0, 32'h80000010, 32'h0,        4'b1111, LC_LW,  32'hA5A55A5A, BUS_RESP_OK,     BUS_RESP_OK,     0, 1'b0, 32'hA5A55A5A, 3, 1, 32'h80000010, 4'b0000, 32'h0};

        rst = 1'b1; req_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
        addr = '0; wdata = '0; wmask = '0; load_ctl = '0;
        clearBus();
        repeat (2) @(negedge clk);
        checkOutput("reset req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("reset valids", {26'b0, arvalid, rready, awvalid, wvalid, bready, resp_valid}, 32'd0);
        checkOutput("reset resp_err", {31'b0, resp_err}, 32'd0);
        checkOutput("reset resp_data", resp_data, 32'd0);
        checkOutput("reset araddr", araddr, 32'd0);
        checkOutput("reset wdata_o", wdata_o, 32'd0);
        checkOutput("reset wstrb", {28'b0, wstrb}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) runVector(vecs[i]);

        // Reset while waiting for read data must abandon the load without a response.
        arready = 1'b1;
        applyStimulus('{"rst mid-read", 1'b1, 1'b0, 32'h80000008, 32'h0, 4'b1111, LC_LW, 32'h0,
                        BUS_RESP_OK, BUS_RESP_OK, 0, 1'b0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0}, 1'b0);
        @(negedge clk);
        checkOutput("rst mid-read arvalid", {31'b0, arvalid}, 32'd1);
        @(negedge clk);
        checkOutput("rst mid-read rready before reset", {31'b0, rready}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst mid-read outputs cleared", {29'b0, arvalid, rready, resp_valid}, 32'd0);
        clearBus();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst mid-read req_ready after release", {31'b0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
